full_adder_9_1: RTL and testbench



---
 rtl/full_adder_9_1.sv | 90 +++++++++
 tb/tb_full_adder_9_1.sv | 119 +++++++++++
 2 files changed

// File: rtl/full_adder_9_1.sv
// Registered single-bit full adder; the arithmetic core is a fixed netlist of
// nine 2-input NAND cells so the gate count is visible after elaboration.

module full_adder_9_1_nand2 (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = ~(x & y);
endmodule

module full_adder_9_1 #(
  parameter bit REG_IN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic core_a, core_b, core_cin;
  logic n1, n2, n3, n4, n5, n6, n7;
  logic s_core, cout_core;
  logic s_d, s_q, cout_d, cout_q;

  generate
    if (REG_IN) begin : g_in_reg
      logic a_d, a_q, b_d, b_q, cin_d, cin_q;

      always_comb begin
        a_d   = a;
        b_d   = b;
        cin_d = cin;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q   <= 1'b0;
          b_q   <= 1'b0;
          cin_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          cin_q <= cin_d;
        end
      end

      assign core_a   = a_q;
      assign core_b   = b_q;
      assign core_cin = cin_q;
    end else begin : g_in_direct
      assign core_a   = a;
      assign core_b   = b;
      assign core_cin = cin;
    end
  endgenerate

  // n4 = a ^ b; the sum repeats the XOR pattern with cin, carry reuses n1/n5.
  full_adder_9_1_nand2 u_n1 (.x(core_a),   .y(core_b),   .z(n1));
  full_adder_9_1_nand2 u_n2 (.x(core_a),   .y(n1),       .z(n2));
  full_adder_9_1_nand2 u_n3 (.x(core_b),   .y(n1),       .z(n3));
  full_adder_9_1_nand2 u_n4 (.x(n2),       .y(n3),       .z(n4));
  full_adder_9_1_nand2 u_n5 (.x(n4),       .y(core_cin), .z(n5));
  full_adder_9_1_nand2 u_n6 (.x(n4),       .y(n5),       .z(n6));
  full_adder_9_1_nand2 u_n7 (.x(core_cin), .y(n5),       .z(n7));
  full_adder_9_1_nand2 u_n8 (.x(n6),       .y(n7),       .z(s_core));
  full_adder_9_1_nand2 u_n9 (.x(n1),       .y(n5),       .z(cout_core));

  always_comb begin
    s_d    = s_core;
    cout_d = cout_core;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_full_adder_9_1.sv
// Bench for full_adder_9_1: both REG_IN builds share one input stream and are
// checked each cycle against an arithmetic reference with a latency pipeline.

module tb_full_adder_9_1;

  logic clk;
  logic rst_n;
  logic a, b, cin;
  logic s1, cout1, s0, cout0;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp1_q[$];
  logic [1:0] exp0_q[$];
  logic [1:0] fly1_q[$];
  logic [1:0] fly0_q[$];

  full_adder_9_1 #(.REG_IN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s1), .cout(cout1)
  );

  full_adder_9_1 #(.REG_IN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s0), .cout(cout0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a result leaves the pipeline after (latency-1) further
  // edges; a reset edge discards everything in flight and the sampled inputs.
  always @(posedge clk) begin
    logic [1:0] sum;
    sum = 2'(a) + 2'(b) + 2'(cin);
    if (!rst_n) begin
      fly1_q = {};
      fly1_q.push_back(2'd0);
      fly0_q = {};
      exp1_q.push_back(2'd0);
      exp0_q.push_back(2'd0);
    end else begin
      fly1_q.push_back(sum);
      exp1_q.push_back(fly1_q.pop_front());
      fly0_q.push_back(sum);
      exp0_q.push_back(fly0_q.pop_front());
    end
  end

  // Monitor: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      tests++;
      if ({cout1, s1} !== e) begin
        fails++;
        $display("FAIL reg_in1 {cout,s} at %0t: got %b expected %b", $time, {cout1, s1}, e);
      end
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      tests++;
      if ({cout0, s0} !== e) begin
        fails++;
        $display("FAIL reg_in0 {cout,s} at %0t: got %b expected %b", $time, {cout0, s0}, e);
      end
    end
  end

  // driver
  task automatic step(input logic ia, input logic ib, input logic ic, input logic ir);
    @(posedge clk);
    #1;
    a     = ia;
    b     = ib;
    cin   = ic;
    rst_n = ir;
  endtask

  initial begin
    logic [2:0] v;
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; cin = 1'b1;

    // reset with all-ones inputs, then release with zeros
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // lab vector: 101 -> sum 0, carry 1
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // exhaustive sweep on consecutive cycles, twice
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        v = 3'(i);
        step(v[2], v[1], v[0], 1'b1);
      end

    // mid-stream reset while streaming 111
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1);

    // random stream with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      v = 3'($urandom_range(0, 7));
      step(v[2], v[1], v[0], ($urandom_range(0, 19) != 0));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
